// File: rtl/commit_trace_buffer.sv
// Commit-point trace monitor: classifies retiring activity into numbered records,
// queues them in a FIFO drained over valid/ready, and flags completion after halt.
module commit_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [15:0]       pc,
  input  logic              reg_write,
  input  logic [2:0]        write_reg,
  input  logic [15:0]       write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [15:0]       rec_inum,
  output logic [15:0]       rec_pc,
  output logic [2:0]        rec_reg,
  output logic [15:0]       rec_value,
  output logic [15:0]       rec_addr,
  output logic [15:0]       rec_mdata,
  output logic [ADDR_W:0]   fifo_count,
  output logic              stall_req,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic [31:0]       cycle_count,
  output logic [15:0]       inst_count,
  output logic              done
);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_DONE} state_t;
  typedef enum logic [2:0] {K_NOP, K_REG, K_LD, K_ST, K_STU, K_HALT} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [2:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] STALL_CNT = (ADDR_W+1)'(DEPTH - 2);

  rec_t              mem [DEPTH];
  rec_t              new_rec;
  rec_t              head_rec;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  state_t            state;
  logic              capture;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign capture = (state == S_RUN) && cap_en;
  assign full    = (count == FULL_CNT);
  assign pop     = rec_valid && rec_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    new_rec      = '0;
    new_rec.inum = inst_count;
    new_rec.pc   = pc;
    if (reg_write && mem_write) begin
      new_rec.kind  = K_STU;
      new_rec.rg    = write_reg;
      new_rec.value = write_data;
      new_rec.addr  = mem_addr;
      new_rec.mdata = mem_data;
    end else if (reg_write && mem_read) begin
      new_rec.kind  = K_LD;
      new_rec.rg    = write_reg;
      new_rec.value = write_data;
      new_rec.addr  = mem_addr;
    end else if (reg_write) begin
      new_rec.kind  = K_REG;
      new_rec.rg    = write_reg;
      new_rec.value = write_data;
    end else if (halt) begin
      new_rec.kind  = K_HALT;
    end else if (mem_write) begin
      new_rec.kind  = K_ST;
      new_rec.addr  = mem_addr;
      new_rec.mdata = mem_data;
    end else begin
      new_rec.kind  = K_NOP;
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= new_rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= S_RUN;
      stall_req   <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      done        <= 1'b0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      count     <= count_next;
      stall_req <= (count_next >= STALL_CNT);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
      if (capture)
        inst_count <= inst_count + 16'd1;
      if (state == S_RUN)
        cycle_count <= cycle_count + 32'd1;
      case (state)
        S_RUN: begin
          // A dropped HALT record still ends capture.
          if (capture && new_rec.kind == K_HALT)
            state <= S_HALTED;
        end
        S_HALTED: begin
          if (count_next == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  done  <= 1'b1;
        default: state <= S_RUN;
      endcase
    end
  end

  assign rec_valid = (count != '0);
  assign head_rec  = rec_valid ? mem[head] : '0;
  assign rec_kind  = head_rec.kind;
  assign rec_inum  = head_rec.inum;
  assign rec_pc    = head_rec.pc;
  assign rec_reg   = head_rec.rg;
  assign rec_value = head_rec.value;
  assign rec_addr  = head_rec.addr;
  assign rec_mdata = head_rec.mdata;
  assign fifo_count = count;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer against a queue-based trace model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_en = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0;
  logic [2:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        halt = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [2:0]  rec_kind;
  logic [15:0] rec_inum, rec_pc, rec_value, rec_addr, rec_mdata;
  logic [2:0]  rec_reg;
  logic [4:0]  fifo_count;
  logic        stall_req, overflow, done;
  logic [7:0]  drop_count;
  logic [31:0] cycle_count;
  logic [15:0] inst_count;

  commit_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value),
    .rec_addr(rec_addr), .rec_mdata(rec_mdata), .fifo_count(fifo_count),
    .stall_req(stall_req), .overflow(overflow), .drop_count(drop_count),
    .cycle_count(cycle_count), .inst_count(inst_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] inum, pc, value, addr, mdata;
    logic [2:0]  rg;
  } trec_t;

  trec_t q[$];
  int    m_state;      // 0 run, 1 halted, 2 done
  int    m_drops;
  bit    m_ovf, m_done;
  int    m_cycles;
  int    m_inst;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_state = 0; m_drops = 0; m_ovf = 0; m_done = 0; m_cycles = 0; m_inst = 0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_step();
    trec_t r;
    bit pop, cap;
    pop = (q.size() != 0) && rec_ready;
    cap = (m_state == 0) && cap_en;
    if (reg_write && mem_write)      r.kind = 4;
    else if (reg_write && mem_read)  r.kind = 2;
    else if (reg_write)              r.kind = 1;
    else if (halt)                   r.kind = 5;
    else if (mem_write)              r.kind = 3;
    else                             r.kind = 0;
    r.inum  = m_inst[15:0];
    r.pc    = pc;
    r.rg    = (r.kind inside {1, 2, 4}) ? write_reg  : 3'd0;
    r.value = (r.kind inside {1, 2, 4}) ? write_data : 16'd0;
    r.addr  = (r.kind inside {2, 3, 4}) ? mem_addr   : 16'd0;
    r.mdata = (r.kind inside {3, 4})    ? mem_data   : 16'd0;
    if (pop) void'(q.pop_front());
    if (m_state == 0) m_cycles++;
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(r);
      else begin m_ovf = 1; m_drops++; end
      m_inst = (m_inst + 1) % 65536;
      if (r.kind == 5) m_state = 1;
    end else if (m_state == 1 && q.size() == 0) begin
      m_state = 2; m_done = 1;
    end
  endfunction

  task automatic check_all();
    trec_t h;
    h = '{kind: 0, inum: 0, pc: 0, value: 0, addr: 0, mdata: 0, rg: 0};
    if (q.size() != 0) h = q[0];
    chk("rec_valid", 32'(rec_valid), 32'(q.size() != 0));
    chk("rec_kind", 32'(rec_kind), 32'(h.kind));
    chk("rec_inum", 32'(rec_inum), 32'(h.inum));
    chk("rec_pc", 32'(rec_pc), 32'(h.pc));
    chk("rec_reg", 32'(rec_reg), 32'(h.rg));
    chk("rec_value", 32'(rec_value), 32'(h.value));
    chk("rec_addr", 32'(rec_addr), 32'(h.addr));
    chk("rec_mdata", 32'(rec_mdata), 32'(h.mdata));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("stall_req", 32'(stall_req), 32'(q.size() >= DEPTH - 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'((m_drops > 255) ? 255 : m_drops));
    chk("cycle_count", cycle_count, 32'(m_cycles));
    chk("inst_count", 32'(inst_count), 32'(m_inst));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic drive(input bit ce, input logic [15:0] p, input bit rw, input logic [2:0] wr,
                       input logic [15:0] wd, input bit mr, input bit mw, input logic [15:0] ma,
                       input logic [15:0] md, input bit h, input bit rdy);
    cap_en = ce; pc = p; reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h; rec_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_cycle(input bit allow_halt, input bit rdy);
    drive(($urandom_range(0, 7) != 0), 16'($urandom), 1'($urandom), 3'($urandom),
          16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          allow_halt && ($urandom_range(0, 31) == 0), rdy);
  endtask

  task automatic commit_nohalt(input bit rdy);
    drive(1'b1, 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
          1'($urandom), 16'($urandom), 16'($urandom), 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cap_en = 1'b0; halt = 1'b0; rec_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt_zero_seen;
    model_reset();
    #2;
    check_all();
    #10;
    rst = 1'b1;

    // Three directed commits with an always-ready sink.
    do_reset();
    idle(1'b1);
    drive(1'b1, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("t1_kind_reg", 32'(rec_kind), 32'd1);
    chk("t1_inum0", 32'(rec_inum), 32'd0);
    chk("t1_value", 32'(rec_value), 32'h1234);
    chk("t1_reg", 32'(rec_reg), 32'd3);
    drive(1'b1, 16'h0002, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b1);
    chk("t1_kind_st", 32'(rec_kind), 32'd3);
    chk("t1_inum1", 32'(rec_inum), 32'd1);
    chk("t1_st_addr", 32'(rec_addr), 32'h0040);
    chk("t1_st_mdata", 32'(rec_mdata), 32'hBEEF);
    drive(1'b1, 16'h0004, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("t1_kind_nop", 32'(rec_kind), 32'd0);
    chk("t1_inum2", 32'(rec_inum), 32'd2);
    chk("t1_nop_pc", 32'(rec_pc), 32'h0004);
    idle(1'b1);
    chk("t1_inst3", 32'(inst_count), 32'd3);
    chk("t1_drained", 32'(rec_valid), 32'd0);

    // All flags at once gives STU and stays in RUN; then HALT freezes capture.
    do_reset();
    drive(1'b1, 16'h0010, 1'b1, 3'd5, 16'hAAAA, 1'b1, 1'b1, 16'h0100, 16'h5555, 1'b1, 1'b0);
    chk("t2_kind_stu", 32'(rec_kind), 32'd4);
    drive(1'b1, 16'h0012, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t2_cycles_frozen", cycle_count, 32'd2);
    for (int i = 0; i < 6; i++) rand_cycle(1'b1, 1'b0);
    chk("t2_inst_hold", 32'(inst_count), 32'd2);
    chk("t2_cycles_hold", cycle_count, 32'd2);

    // Blocked sink for DEPTH+3 commits, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      commit_nohalt(1'b0);
      if (i == 12) chk("t3_stall_13", 32'(stall_req), 32'd0);
      if (i == 13) chk("t3_stall_14", 32'(stall_req), 32'd1);
    end
    chk("t3_count16", 32'(fifo_count), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drops3", 32'(drop_count), 32'd3);
    chk("t3_inst19", 32'(inst_count), 32'd19);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_drain_inum", 32'(rec_inum), 32'(i));
      idle(1'b1);
    end

    // Full FIFO accepts a push when a pop happens in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) commit_nohalt(1'b0);
    commit_nohalt(1'b1);
    chk("t4_count_full", 32'(fifo_count), 32'd16);
    chk("t4_no_drop", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // HALT with a backlog and a toggling sink.
    do_reset();
    for (int i = 0; i < 5; i++) commit_nohalt(1'b0);
    drive(1'b1, 16'h0200, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cnt_zero_seen = 0;
    for (int i = 0; i < 40 && cnt_zero_seen == 0; i++) begin
      chk("t5_done_early", 32'(done), 32'd0);
      rand_cycle(1'b1, 1'(i % 2 == 0));
      if (fifo_count == 0) begin
        cnt_zero_seen = 1;
        chk("t5_done_at_empty", 32'(done), 32'd1);
      end
    end
    chk("t5_reached_empty", 32'(cnt_zero_seen), 32'd1);
    for (int i = 0; i < 5; i++) rand_cycle(1'b1, 1'($urandom));
    chk("t5_done_sticky", 32'(done), 32'd1);

    // Random traffic across several reset epochs.
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int i = 0; i < 150; i++) rand_cycle(1'b1, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 10; i++) commit_nohalt(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t6_count7", 32'(fifo_count), 32'd7);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", 32'(rec_valid), 32'd0);
    chk("t6_async_cycles", cycle_count, 32'd0);
    chk("t6_async_inst", 32'(inst_count), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    rec_ready = 1'b0;
    idle(1'b0);
    chk("t6_run_after", cycle_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
